uart_tx_mmio: RTL and testbench

UART_TX_MMIO -- requirements
Module: uart_tx_mmio

---
 rtl/nitc_io_pkg.sv | 23 ++
 rtl/uart_tx_mmio_if.sv | 15 +
 rtl/sync_fifo.sv | 52 +++++
 rtl/uart_tx_mmio.sv | 129 ++++++++++++
 tb/tb_uart_tx_mmio.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/nitc_io_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: default register
// addresses, status register bit positions and the serialiser state encoding.
package nitc_io_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  localparam logic [ADDR_W-1:0] TX_ADDR_DEF   = 16'hFF00;
  localparam logic [ADDR_W-1:0] STAT_ADDR_DEF = 16'hFF01;

  localparam int STAT_BUSY  = 0;
  localparam int STAT_EMPTY = 1;
  localparam int STAT_FULL  = 2;
  localparam int STAT_OVF   = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_e;

endpackage

// File: rtl/uart_tx_mmio_if.sv
// CPU store/load port seen by a memory-mapped peripheral; sel and readdata are
// combinational replies to the address currently on the bus.
interface uart_tx_mmio_if;
  import nitc_io_pkg::*;

  logic [ADDR_W-1:0] adr;
  logic [DATA_W-1:0] writedata;
  logic              memwrite;
  logic              sel;
  logic [DATA_W-1:0] readdata;

  modport master (output adr, writedata, memwrite, input sel, readdata);
  modport slave  (input adr, writedata, memwrite, output sel, readdata);

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO, read data shown combinationally at the head; writes land
// one edge after push. A push while full is taken only if a pop shares the edge.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       wdat_i,
  output logic [WIDTH-1:0]       rdat_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign pop_ok  = pop_i && !empty_o;
  // The head slot is read before the edge, so a full FIFO can reuse it for the push.
  assign push_ok = push_i && (!full_o || pop_ok);
  assign rdat_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdat_i;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: stores to TX_ADDR queue bytes, txd falls the edge after
// a push into an idle empty unit; no stall path, so pushes into a full FIFO are dropped and flagged.
module uart_tx_mmio import nitc_io_pkg::*; #(
  parameter int                CLKS_PER_BIT = 16,
  parameter int                DEPTH        = 4,
  parameter logic [ADDR_W-1:0] TX_ADDR      = TX_ADDR_DEF,
  parameter logic [ADDR_W-1:0] STAT_ADDR    = STAT_ADDR_DEF
) (
  input  logic          clk,
  input  logic          reset,
  uart_tx_mmio_if.slave bus,
  output logic          txd,
  output logic          busy,
  output logic          overflow
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(DEPTH) + 1;

  tx_state_e         state_q;
  logic [7:0]        shift_q;
  logic [2:0]        bit_q;
  logic [BW-1:0]     baud_q;
  logic              txd_q, ovf_q, ovf_d;
  logic              tx_hit, st_hit, push, pop, baud_last;
  logic              fifo_full, fifo_empty;
  logic [7:0]        fifo_dat;
  logic [CW-1:0]     fifo_cnt;
  logic [DATA_W-1:0] status;
  logic              unused_wdat;

  assign tx_hit    = (bus.adr == TX_ADDR);
  assign st_hit    = (bus.adr == STAT_ADDR);
  assign bus.sel   = tx_hit || st_hit;
  assign push      = bus.memwrite && tx_hit;
  assign pop       = (state_q == ST_IDLE) && !fifo_empty;
  assign baud_last = (baud_q == BW'(CLKS_PER_BIT - 1));
  assign unused_wdat = ^bus.writedata[15:8];

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push_i (push),
    .pop_i  (pop),
    .wdat_i (bus.writedata[7:0]),
    .rdat_o (fifo_dat),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .count_o(fifo_cnt)
  );

  always_comb begin
    status            = '0;
    status[STAT_BUSY]  = busy;
    status[STAT_EMPTY] = fifo_empty;
    status[STAT_FULL]  = fifo_full;
    status[STAT_OVF]   = ovf_q;
  end
  assign bus.readdata = st_hit ? status : '0;

  always_comb begin
    ovf_d = ovf_q;
    if (push && fifo_full && !pop) ovf_d = 1'b1;
    else if (bus.memwrite && st_hit && bus.writedata[0]) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      baud_q  <= '0;
      txd_q   <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      case (state_q)
        ST_IDLE: begin
          baud_q <= '0;
          txd_q  <= !pop;
          if (pop) begin
            shift_q <= fifo_dat;
            state_q <= ST_START;
          end
        end
        ST_START: begin
          if (baud_last) begin
            baud_q  <= '0;
            bit_q   <= '0;
            txd_q   <= shift_q[0];
            state_q <= ST_DATA;
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        ST_DATA: begin
          if (baud_last) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
              txd_q   <= 1'b1;
              state_q <= ST_STOP;
            end else begin
              bit_q   <= bit_q + 3'd1;
              shift_q <= {1'b0, shift_q[7:1]};
              txd_q   <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        ST_STOP: begin
          if (baud_last) begin
            baud_q  <= '0;
            state_q <= ST_IDLE;
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign txd      = txd_q;
  assign busy     = (state_q != ST_IDLE);
  assign overflow = ovf_q;

  a_count_range: assert property (@(posedge clk) disable iff (!reset) fifo_cnt <= CW'(DEPTH));

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio with CLKS_PER_BIT=4, DEPTH=4; expected waveforms and
// status words are hand-derived, edge numbers E1.. count from the first store of each scenario.
module tb_uart_tx_mmio;
  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  logic clk = 1'b0;
  logic reset;
  logic txd, busy, overflow;
  int   n_checks = 0;
  int   n_errors = 0;

  uart_tx_mmio_if bus ();

  uart_tx_mmio #(
    .CLKS_PER_BIT(CPB),
    .DEPTH       (4),
    .TX_ADDR     (16'hFF00),
    .STAT_ADDR   (16'hFF01)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .txd     (txd),
    .busy    (busy),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [15:0] a, input logic [15:0] d);
    bus.adr       = a;
    bus.writedata = d;
    bus.memwrite  = 1'b1;
    tick();
    bus.memwrite  = 1'b0;
    bus.adr       = 16'h0000;
    bus.writedata = 16'h0000;
  endtask

  task automatic check_stat(input string tag, input logic [15:0] exp);
    bus.adr = 16'hFF01;
    #1;
    check(tag, 64'(bus.readdata), 64'(exp));
    bus.adr = 16'h0000;
  endtask

  function automatic logic [FRAME-1:0] frame_exp(input logic [7:0] b);
    logic [9:0]       bits;
    logic [FRAME-1:0] w;
    bits = {1'b1, b, 1'b0};
    for (int k = 0; k < FRAME; k++) w[k] = bits[k / CPB];
    return w;
  endfunction

  // Samples the FRAME edges that follow, then the single idle edge after them.
  task automatic check_frame(input string tag, input logic [7:0] b);
    logic [FRAME-1:0] tx, bz;
    for (int k = 0; k < FRAME; k++) begin
      tick();
      tx[k] = txd;
      bz[k] = busy;
    end
    check({tag, "_txd"}, 64'(tx), 64'(frame_exp(b)));
    check({tag, "_busy"}, 64'(bz), 64'({FRAME{1'b1}}));
    tick();
    check({tag, "_gap"}, 64'({busy, txd}), 64'h1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int bad;
    bus.adr       = 16'h0000;
    bus.writedata = 16'h0000;
    bus.memwrite  = 1'b0;
    reset         = 1'b0;

    // Reset state
    #12;
    check("rst_txd", 64'(txd), 64'h1);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_ovf", 64'(overflow), 64'h0);
    check_stat("rst_stat", 16'h0002);
    bus.adr = 16'hFF00;
    #1;
    check("sel_tx", 64'(bus.sel), 64'h1);
    check("rd_tx_zero", 64'(bus.readdata), 64'h0);
    bus.adr = 16'h0000;
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Store to an unrelated address
    bus.adr       = 16'h0040;
    bus.writedata = 16'h00AA;
    bus.memwrite  = 1'b1;
    #1;
    check("sel_other", 64'(bus.sel), 64'h0);
    check("rd_other", 64'(bus.readdata), 64'h0);
    tick();
    bus.memwrite = 1'b0;
    bus.adr      = 16'h0000;
    repeat (3) tick();
    check("other_idle", 64'({busy, txd}), 64'h1);
    check_stat("other_stat", 16'h0002);

    // Single byte 0x55, upper half of the store ignored
    store(16'hFF00, 16'h1255);
    check_frame("f55", 8'h55);

    // Six back-to-back pushes: 01 pops at E2, 02..05 fill, 06 dropped at E6
    for (int i = 1; i <= 6; i++) store(16'hFF00, {8'h00, 8'(i)});
    check("ovf_set", 64'(overflow), 64'h1);
    check_stat("stat_full_ovf", 16'h000D);
    store(16'hFF01, 16'h0001);
    check("ovf_clr", 64'(overflow), 64'h0);
    check_stat("stat_full", 16'h0005);
    repeat (34) tick();
    check("b01_stop_busy", 64'(busy), 64'h1);
    tick();
    check("b01_gap", 64'({busy, txd}), 64'h1);
    for (int i = 2; i <= 5; i++) check_frame($sformatf("b%0d", i), 8'(i));
    repeat (4) tick();
    check("no_b06", 64'({busy, txd}), 64'h1);
    check_stat("drained", 16'h0002);

    // Push into a full FIFO on the very edge IDLE pops (E43)
    for (int i = 0; i < 5; i++) store(16'hFF00, {8'h00, 8'hA0 + 8'(i)});
    check_stat("pre_full", 16'h0005);
    repeat (37) tick();
    check("a0_gap", 64'({busy, txd}), 64'h1);
    store(16'hFF00, 16'h00A5);
    check("simul_ovf", 64'(overflow), 64'h0);
    check_stat("simul_full", 16'h0005);
    repeat (40) tick();
    check("a1_gap", 64'({busy, txd}), 64'h1);
    for (int i = 2; i <= 5; i++) check_frame($sformatf("a%0d", i), 8'hA0 + 8'(i));
    check_stat("a_drained", 16'h0002);

    // Reset during data bit 3 of 0xF7 with two bytes queued
    store(16'hFF00, 16'h00F7);
    store(16'hFF00, 16'h00B1);
    store(16'hFF00, 16'h00B2);
    repeat (16) tick();
    check("bit3_low", 64'(txd), 64'h0);
    check_stat("two_queued", 16'h0001);
    #2;
    reset = 1'b0;
    #1;
    check("abort_txd", 64'(txd), 64'h1);
    check("abort_busy", 64'(busy), 64'h0);
    check_stat("abort_stat", 16'h0002);
    tick();
    tick();
    reset = 1'b1;
    bad = 0;
    repeat (60) begin
      tick();
      if (busy || !txd) bad++;
    end
    check("no_resume", 64'(bad), 64'h0);

    // First push after reset release
    store(16'hFF00, 16'h003C);
    check_frame("post_rst", 8'h3C);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
